// File: rtl/pauli_row_acc_bank.sv
// Bank of Pauli-row accumulators: clear, load, multiply and multi-step rotate.
// Optional per-accumulator anticommutation flag on MULT: define ANTICOMM_CHECK_EN.
module pauli_row_acc_bank #(
    parameter int NUM_QUBIT = 4,
    parameter int NUM_ACC   = 2,
    parameter int AMT_W     = 4
) (
    input  logic                           clk,
    input  logic                           rst_new,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [2:0]                     cmd_op,
    input  logic [NUM_ACC-1:0]             cmd_sel,
    input  logic [AMT_W-1:0]               cmd_amt,
    input  logic [1:0]                     src_literals [0:NUM_QUBIT-1],
    input  logic                           src_phase,
    input  logic [1:0]                     row_literals [0:NUM_QUBIT-1],
    input  logic                           row_phase,
    output logic [2*NUM_QUBIT*NUM_ACC-1:0] acc_literals,
    output logic [NUM_ACC-1:0]             acc_phase,
    output logic                           done,
    output logic [NUM_ACC-1:0]             mult_anticomm
);

    localparam logic [2:0] OP_CLEAR = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_MULT  = 3'd2;
    localparam logic [2:0] OP_ROTL  = 3'd3;
    localparam logic [2:0] OP_ROTR  = 3'd4;

    typedef enum logic [0:0] {IDLE, ROT} state_t;
    typedef logic [NUM_QUBIT-1:0][1:0] row_t;

    state_t                    state_q, state_d;
    logic [AMT_W-1:0]          cnt_q, cnt_d;
    logic [NUM_ACC-1:0]        sel_q, sel_d;
    logic                      dir_q, dir_d;
    row_t [NUM_ACC-1:0]        lit_q, lit_d;
    logic [NUM_ACC-1:0]        ph_q, ph_d;
    logic                      done_q, done_d;
    row_t                      src_p, row_p;
    logic [AMT_W-1:0]          eff;
    logic                      accept;

    // Phase contribution of one qubit product in powers of i, mod 4
    function automatic logic [1:0] g_fn(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] g;
        g = 2'd0;
        unique case (a)
            2'b00: g = 2'd0;
            2'b11: g = {1'b0, b[0]} - {1'b0, b[1]};
            2'b10: g = b[0] ? (b[1] ? 2'd1 : 2'd3) : 2'd0;
            2'b01: g = b[1] ? (b[0] ? 2'd3 : 2'd1) : 2'd0;
            default: g = 2'd0;
        endcase
        return g;
    endfunction

    function automatic logic mult_phase(input row_t a, input logic pa,
                                        input row_t b, input logic pb);
        logic [1:0] s;
        s = {pa, 1'b0} + {pb, 1'b0};
        for (int i = 0; i < NUM_QUBIT; i++) begin
            s = s + g_fn(a[i], b[i]);
        end
        return s[1];
    endfunction

    always_comb begin
        src_p = '0;
        row_p = '0;
        for (int i = 0; i < NUM_QUBIT; i++) begin
            src_p[i] = src_literals[i];
            row_p[i] = row_literals[i];
        end
    end

    assign eff       = AMT_W'(32'(cmd_amt) % 32'(NUM_QUBIT));
    assign accept    = cmd_valid && (state_q == IDLE);
    assign cmd_ready = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        lit_d   = lit_q;
        ph_d    = ph_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    done_d = 1'b1;
                    unique case (1'b1)
                        (cmd_op == OP_CLEAR): begin
                            for (int k = 0; k < NUM_ACC; k++) begin
                                if (cmd_sel[k]) begin
                                    lit_d[k] = '0;
                                    ph_d[k]  = 1'b0;
                                end
                            end
                        end
                        (cmd_op == OP_LOAD): begin
                            for (int k = 0; k < NUM_ACC; k++) begin
                                if (cmd_sel[k]) begin
                                    lit_d[k] = src_p;
                                    ph_d[k]  = src_phase;
                                end
                            end
                        end
                        (cmd_op == OP_MULT): begin
                            for (int k = 0; k < NUM_ACC; k++) begin
                                if (cmd_sel[k]) begin
                                    lit_d[k] = lit_q[k] ^ row_p;
                                    ph_d[k]  = mult_phase(lit_q[k], ph_q[k],
                                                          row_p, row_phase);
                                end
                            end
                        end
                        (cmd_op == OP_ROTL),
                        (cmd_op == OP_ROTR): begin
                            if (eff != '0) begin
                                state_d = ROT;
                                cnt_d   = eff;
                                sel_d   = cmd_sel;
                                dir_d   = (cmd_op == OP_ROTR);
                                done_d  = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ROT: begin
                // dir_q: 0 = left (new[i]=old[i+1]), 1 = right (new[i]=old[i-1])
                for (int k = 0; k < NUM_ACC; k++) begin
                    if (sel_q[k]) begin
                        for (int i = 0; i < NUM_QUBIT; i++) begin
                            lit_d[k][i] = dir_q
                                ? lit_q[k][(i + NUM_QUBIT - 1) % NUM_QUBIT]
                                : lit_q[k][(i + 1) % NUM_QUBIT];
                        end
                    end
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == AMT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_new) begin
        if (rst_new) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            dir_q   <= 1'b0;
            lit_q   <= '0;
            ph_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
            lit_q   <= lit_d;
            ph_q    <= ph_d;
            done_q  <= done_d;
        end
    end

    assign acc_literals = lit_q;
    assign acc_phase    = ph_q;
    assign done         = done_q;

`ifdef ANTICOMM_CHECK_EN
    logic [NUM_ACC-1:0] ac_q, ac_d;

    // Odd sum iff an odd number of qubit pairs are distinct non-identity literals
    function automatic logic mult_odd(input row_t a, input row_t b);
        logic o;
        o = 1'b0;
        for (int i = 0; i < NUM_QUBIT; i++) begin
            o = o ^ ((a[i] != 2'b00) && (b[i] != 2'b00) && (a[i] != b[i]));
        end
        return o;
    endfunction

    always_comb begin
        ac_d = ac_q;
        if (accept) begin
            ac_d = '0;
            if (cmd_op == OP_MULT) begin
                for (int k = 0; k < NUM_ACC; k++) begin
                    ac_d[k] = cmd_sel[k] && mult_odd(lit_q[k], row_p);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst_new) begin
        if (rst_new) ac_q <= '0;
        else         ac_q <= ac_d;
    end

    assign mult_anticomm = ac_q;
`else
    assign mult_anticomm = '0;
`endif

endmodule

// File: tb/tb_pauli_row_acc_bank.sv
// Directed bench for pauli_row_acc_bank with hand-computed expectations.
// Anticommutation expectations follow ANTICOMM_CHECK_EN.
module tb_pauli_row_acc_bank;

    localparam int NQ = 4;
    localparam int NA = 2;
    localparam int AW = 4;
    localparam logic [1:0] LI = 2'b00;
    localparam logic [1:0] LZ = 2'b01;
    localparam logic [1:0] LX = 2'b10;
    localparam logic [1:0] LY = 2'b11;
`ifdef ANTICOMM_CHECK_EN
    localparam logic [1:0] AC_EXP = 2'b01;
`else
    localparam logic [1:0] AC_EXP = 2'b00;
`endif

    logic            clk = 1'b0;
    logic            rst_new = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [2:0]      cmd_op = 3'd0;
    logic [NA-1:0]   cmd_sel = '0;
    logic [AW-1:0]   cmd_amt = '0;
    logic [1:0]      src_literals [0:NQ-1];
    logic            src_phase = 1'b0;
    logic [1:0]      row_literals [0:NQ-1];
    logic            row_phase = 1'b0;
    logic [2*NQ*NA-1:0] acc_literals;
    logic [NA-1:0]   acc_phase;
    logic            done;
    logic [NA-1:0]   mult_anticomm;

    int nvec = 0;
    int nmis = 0;

    pauli_row_acc_bank #(.NUM_QUBIT(NQ), .NUM_ACC(NA), .AMT_W(AW)) dut (
        .clk(clk), .rst_new(rst_new),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_amt(cmd_amt),
        .src_literals(src_literals), .src_phase(src_phase),
        .row_literals(row_literals), .row_phase(row_phase),
        .acc_literals(acc_literals), .acc_phase(acc_phase),
        .done(done), .mult_anticomm(mult_anticomm)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] r4(input logic [1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic set_src(input logic [1:0] a, b, c, d, input logic p);
        src_literals[0] = a; src_literals[1] = b;
        src_literals[2] = c; src_literals[3] = d;
        src_phase = p;
    endtask

    task automatic set_row(input logic [1:0] a, b, c, d, input logic p);
        row_literals[0] = a; row_literals[1] = b;
        row_literals[2] = c; row_literals[3] = d;
        row_phase = p;
    endtask

    // Present one command for a single cycle; returns at the negedge after accept
    task automatic issue(input logic [2:0] op, input logic [NA-1:0] sel,
                         input logic [AW-1:0] amt);
        @(negedge clk);
        cmd_op = op; cmd_sel = sel; cmd_amt = amt; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_new = 1'b1;
        repeat (2) @(negedge clk);
        nvec++; if (acc_literals !== 16'h0000) begin nmis++;
            $display("FAIL reset_lits: got %h want 0000", acc_literals); end
        nvec++; if (acc_phase !== 2'b00) begin nmis++;
            $display("FAIL reset_phase: got %b want 00", acc_phase); end
        nvec++; if ({done, cmd_ready} !== 2'b01) begin nmis++;
            $display("FAIL reset_done_ready: got %b want 01", {done, cmd_ready}); end
        nvec++; if (mult_anticomm !== 2'b00) begin nmis++;
            $display("FAIL reset_ac: got %b want 00", mult_anticomm); end
        rst_new = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load;
        set_src(LX, LZ, LI, LY, 1'b1);
        issue(3'd1, 2'b01, 4'd0);
        nvec++; if (acc_literals !== {8'h00, r4(LX, LZ, LI, LY)}) begin nmis++;
            $display("FAIL load_lits: got %h want %h", acc_literals,
                     {8'h00, r4(LX, LZ, LI, LY)}); end
        nvec++; if (acc_phase !== 2'b01) begin nmis++;
            $display("FAIL load_phase: got %b want 01", acc_phase); end
        nvec++; if ({done, cmd_ready} !== 2'b11) begin nmis++;
            $display("FAIL load_done: got %b want 11", {done, cmd_ready}); end
        @(negedge clk);
        nvec++; if (done !== 1'b0) begin nmis++;
            $display("FAIL load_done_width: got %b want 0", done); end
    endtask

    task automatic test_rotate;
        issue(3'd3, 2'b01, 4'd1);
        nvec++; if ({done, cmd_ready} !== 2'b00) begin nmis++;
            $display("FAIL rotl_busy: got %b want 00", {done, cmd_ready}); end
        @(negedge clk);
        nvec++; if (acc_literals !== {8'h00, r4(LZ, LI, LY, LX)}) begin nmis++;
            $display("FAIL rotl_lits: got %h want %h", acc_literals,
                     {8'h00, r4(LZ, LI, LY, LX)}); end
        nvec++; if ({done, cmd_ready, acc_phase} !== 4'b1101) begin nmis++;
            $display("FAIL rotl_done: got %b want 1101",
                     {done, cmd_ready, acc_phase}); end
        issue(3'd4, 2'b01, 4'd5);
        nvec++; if (cmd_ready !== 1'b0) begin nmis++;
            $display("FAIL rotr_busy: got %b want 0", cmd_ready); end
        @(negedge clk);
        nvec++; if (acc_literals !== {8'h00, r4(LX, LZ, LI, LY)}) begin nmis++;
            $display("FAIL rotr_lits: got %h want %h", acc_literals,
                     {8'h00, r4(LX, LZ, LI, LY)}); end
        nvec++; if (done !== 1'b1) begin nmis++;
            $display("FAIL rotr_done: got %b want 1", done); end
    endtask

    task automatic test_mult;
        set_src(LX, LX, LI, LI, 1'b0);
        issue(3'd1, 2'b11, 4'd0);
        set_row(LZ, LZ, LI, LI, 1'b0);
        issue(3'd2, 2'b11, 4'd0);
        nvec++; if (acc_literals !== {r4(LY, LY, LI, LI), r4(LY, LY, LI, LI)})
            begin nmis++;
            $display("FAIL mult_lits: got %h want %h", acc_literals,
                     {r4(LY, LY, LI, LI), r4(LY, LY, LI, LI)}); end
        nvec++; if (acc_phase !== 2'b11) begin nmis++;
            $display("FAIL mult_phase: got %b want 11", acc_phase); end
        nvec++; if (mult_anticomm !== 2'b00) begin nmis++;
            $display("FAIL mult_ac: got %b want 00", mult_anticomm); end
        nvec++; if (done !== 1'b1) begin nmis++;
            $display("FAIL mult_done: got %b want 1", done); end
    endtask

    task automatic test_anticomm;
        set_src(LX, LI, LI, LI, 1'b0);
        issue(3'd1, 2'b01, 4'd0);
        set_row(LZ, LI, LI, LI, 1'b0);
        issue(3'd2, 2'b01, 4'd0);
        nvec++; if (acc_literals !== {r4(LY, LY, LI, LI), r4(LY, LI, LI, LI)})
            begin nmis++;
            $display("FAIL ac_lits: got %h want %h", acc_literals,
                     {r4(LY, LY, LI, LI), r4(LY, LI, LI, LI)}); end
        nvec++; if (acc_phase !== 2'b11) begin nmis++;
            $display("FAIL ac_phase: got %b want 11", acc_phase); end
        nvec++; if (mult_anticomm !== AC_EXP) begin nmis++;
            $display("FAIL ac_flag: got %b want %b", mult_anticomm, AC_EXP); end
        issue(3'd0, 2'b01, 4'd0);
        nvec++; if (acc_literals !== {r4(LY, LY, LI, LI), 8'h00}) begin nmis++;
            $display("FAIL clear_lits: got %h want %h", acc_literals,
                     {r4(LY, LY, LI, LI), 8'h00}); end
        nvec++; if ({acc_phase, mult_anticomm, done} !== 5'b10001) begin nmis++;
            $display("FAIL clear_flags: got %b want 10001",
                     {acc_phase, mult_anticomm, done}); end
    endtask

    task automatic test_rot_reset;
        int seen;
        set_src(LX, LZ, LI, LY, 1'b1);
        issue(3'd1, 2'b01, 4'd0);
        issue(3'd3, 2'b01, 4'd3);
        @(negedge clk);
        nvec++; if (acc_literals[7:0] !== r4(LZ, LI, LY, LX)) begin nmis++;
            $display("FAIL rr_shift1: got %h want %h", acc_literals[7:0],
                     r4(LZ, LI, LY, LX)); end
        rst_new = 1'b1;
        #1;
        nvec++; if ({acc_literals, acc_phase, done} !== 19'd0) begin nmis++;
            $display("FAIL rr_cleared: got %h/%b/%b want 0", acc_literals,
                     acc_phase, done); end
        @(negedge clk);
        rst_new = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0) seen++;
        end
        nvec++; if (seen != 0) begin nmis++;
            $display("FAIL rr_no_done: got %0d pulses want 0", seen); end
        nvec++; if ({cmd_ready, acc_literals} !== {1'b1, 16'h0000}) begin nmis++;
            $display("FAIL rr_idle: got %b/%h want 1/0000", cmd_ready,
                     acc_literals); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] lits;
        set_src(LX, LZ, LI, LY, 1'b1);
        issue(3'd1, 2'b11, 4'd0);
        lits = {r4(LX, LZ, LI, LY), r4(LX, LZ, LI, LY)};
        @(negedge clk);
        cmd_op = 3'd3; cmd_sel = 2'b11; cmd_amt = 4'd4; cmd_valid = 1'b1;
        @(negedge clk);
        nvec++; if ({done, cmd_ready} !== 2'b11) begin nmis++;
            $display("FAIL b2b_rot0: got %b want 11", {done, cmd_ready}); end
        cmd_op = 3'd6;
        @(negedge clk);
        nvec++; if ({done, cmd_ready} !== 2'b11) begin nmis++;
            $display("FAIL b2b_nop: got %b want 11", {done, cmd_ready}); end
        set_row(LY, LY, LY, LY, 1'b1);
        cmd_op = 3'd2; cmd_sel = 2'b00;
        @(negedge clk);
        cmd_valid = 1'b0;
        nvec++; if (done !== 1'b1) begin nmis++;
            $display("FAIL b2b_zero_mask: got %b want 1", done); end
        nvec++; if ({acc_literals, acc_phase} !== {lits, 2'b11}) begin nmis++;
            $display("FAIL b2b_unchanged: got %h/%b want %h/11", acc_literals,
                     acc_phase, lits); end
        @(negedge clk);
        nvec++; if (done !== 1'b0) begin nmis++;
            $display("FAIL b2b_done_drop: got %b want 0", done); end
    endtask

    initial begin
        set_src(LI, LI, LI, LI, 1'b0);
        set_row(LI, LI, LI, LI, 1'b0);
        test_reset();
        test_load();
        test_rotate();
        test_mult();
        test_anticomm();
        test_rot_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
